// File: rtl/flag_div_pkg.sv
// Shared types and helpers for the flag divider scheduler: config FSM states,
// the reset divide ratio and the channel-index width function.
package flag_div_pkg;

   localparam int RST_DIV_DEF = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PEND = 2'd1,
      ST_DONE = 2'd2
   } cfg_state_e;

   // Width of a channel index; at least one bit even for a single channel.
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/flag_div_sched_if.sv
// Config port of the flag divider scheduler.
// Handshake: a request transfers on a rising edge where cfg_valid & cfg_ready;
// the requester keeps cfg_valid and the payload stable until that edge.
// Optional FLAG_DIV_SCHED_PHASE_EN adds the cfg_phase payload field.
interface flag_div_sched_if
   import flag_div_pkg::*;
#(
   parameter int NCH   = 4,
   parameter int DIV_W = 8
);
   localparam int CH_W = ch_w(NCH);

   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [DIV_W-1:0] cfg_div;
   logic             cfg_en;
   logic             cfg_done;
   logic             cfg_err;
`ifdef FLAG_DIV_SCHED_PHASE_EN
   logic [DIV_W-1:0] cfg_phase;
`endif

   modport master (
`ifdef FLAG_DIV_SCHED_PHASE_EN
      output cfg_phase,
`endif
      output cfg_valid, cfg_ch, cfg_div, cfg_en,
      input  cfg_ready, cfg_done, cfg_err
   );

   modport slave (
`ifdef FLAG_DIV_SCHED_PHASE_EN
      input  cfg_phase,
`endif
      input  cfg_valid, cfg_ch, cfg_div, cfg_en,
      output cfg_ready, cfg_done, cfg_err
   );

endinterface

// File: rtl/flag_div_chan.sv
// One flag divider channel: counter, active divide ratio and enable.
// New settings load on commit_i; sync_i restarts the period and drops the flag.
// With FLAG_DIV_SCHED_PHASE_EN the flag fires at cnt==phase instead of the wrap.
module flag_div_chan #(
   parameter int DIV_W   = 8,
   parameter int RST_DIV = 5
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             commit_i,
   input  logic [DIV_W-1:0] div_i,
   input  logic             en_i,
`ifdef FLAG_DIV_SCHED_PHASE_EN
   input  logic [DIV_W-1:0] phase_i,
`endif
   input  logic             sync_i,
   output logic             flag_o,
   output logic             wrap_o,
   output logic             en_o
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             en_q, en_d;
   logic             flag_q, flag_d;
   logic             last;
   logic             fire;

   assign last = (cnt_q == (div_q - DIV_W'(1)));

`ifdef FLAG_DIV_SCHED_PHASE_EN
   logic [DIV_W-1:0] phase_q, phase_d;
   assign fire = en_q & (cnt_q == phase_q);
`else
   assign fire = en_q & last;
`endif

   assign flag_o = flag_q;
   assign wrap_o = en_q & last;
   assign en_o   = en_q;

   // Next counter/settings: count while enabled, load on commit, restart on sync.
   always_comb begin
      cnt_d  = cnt_q;
      div_d  = div_q;
      en_d   = en_q;
      flag_d = fire;
`ifdef FLAG_DIV_SCHED_PHASE_EN
      phase_d = phase_q;
`endif
      if (en_q) begin
         cnt_d = last ? '0 : cnt_q + DIV_W'(1);
      end else begin
         cnt_d = '0;
      end
      // Commit only happens at a wrap, while disabled, or with sync,
      // so the new period always starts from zero.
      if (commit_i) begin
         div_d = div_i;
         en_d  = en_i;
         cnt_d = '0;
`ifdef FLAG_DIV_SCHED_PHASE_EN
         phase_d = phase_i;
`endif
      end
      if (sync_i) begin
         cnt_d  = '0;
         flag_d = 1'b0;
      end
   end

   // Channel state register.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_q  <= '0;
         div_q  <= DIV_W'(RST_DIV);
         en_q   <= 1'b0;
         flag_q <= 1'b0;
`ifdef FLAG_DIV_SCHED_PHASE_EN
         phase_q <= '0;
`endif
      end else begin
         cnt_q  <= cnt_d;
         div_q  <= div_d;
         en_q   <= en_d;
         flag_q <= flag_d;
`ifdef FLAG_DIV_SCHED_PHASE_EN
         phase_q <= phase_d;
`endif
      end
   end

endmodule

// File: rtl/flag_div_sched.sv
// Runtime-programmable scheduler for NCH clock-enable flag dividers.
// Holds the config FSM (IDLE/PEND/DONE), the shadow request and the legality
// checks; a request commits to its channel at that channel's wrap, while the
// channel is disabled, or on sync_req. Optional macro: FLAG_DIV_SCHED_PHASE_EN.
module flag_div_sched
   import flag_div_pkg::*;
#(
   parameter int NCH     = 4,
   parameter int DIV_W   = 8,
   parameter int RST_DIV = RST_DIV_DEF
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   flag_div_sched_if.slave  cfg,
   input  logic             sync_req,
   output logic [NCH-1:0]   clk_flag,
   output cfg_state_e       dbg_state_o
);

   localparam int CH_W = ch_w(NCH);

   cfg_state_e       state_q, state_d;
   logic [CH_W-1:0]  sh_ch_q, sh_ch_d;
   logic [DIV_W-1:0] sh_div_q, sh_div_d;
   logic             sh_en_q, sh_en_d;
   logic             err_q, err_d;
   logic             commit;
   logic             hs;
   logic             req_ok;
   logic [NCH-1:0]   wrap;
   logic [NCH-1:0]   chan_en;

`ifdef FLAG_DIV_SCHED_PHASE_EN
   logic [DIV_W-1:0] sh_ph_q, sh_ph_d;
   assign req_ok = (int'(cfg.cfg_ch) < NCH) && (cfg.cfg_div != '0) &&
                   (cfg.cfg_phase < cfg.cfg_div);
`else
   assign req_ok = (int'(cfg.cfg_ch) < NCH) && (cfg.cfg_div != '0);
`endif

   assign hs            = cfg.cfg_valid & cfg.cfg_ready;
   assign cfg.cfg_ready = (state_q == ST_IDLE);
   assign cfg.cfg_done  = (state_q == ST_DONE);
   assign cfg.cfg_err   = err_q;
   assign dbg_state_o   = state_q;

   // Config FSM next state, shadow capture, commit decision and error pulse.
   always_comb begin
      state_d  = state_q;
      sh_ch_d  = sh_ch_q;
      sh_div_d = sh_div_q;
      sh_en_d  = sh_en_q;
      err_d    = 1'b0;
      commit   = 1'b0;
`ifdef FLAG_DIV_SCHED_PHASE_EN
      sh_ph_d  = sh_ph_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (hs) begin
               if (req_ok) begin
                  sh_ch_d  = cfg.cfg_ch;
                  sh_div_d = cfg.cfg_div;
                  sh_en_d  = cfg.cfg_en;
`ifdef FLAG_DIV_SCHED_PHASE_EN
                  sh_ph_d  = cfg.cfg_phase;
`endif
                  state_d  = ST_PEND;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_PEND: begin
            if (sync_req || wrap[sh_ch_q] || !chan_en[sh_ch_q]) begin
               commit  = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Config FSM and shadow registers; reset discards any pending request.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q  <= ST_IDLE;
         sh_ch_q  <= '0;
         sh_div_q <= '0;
         sh_en_q  <= 1'b0;
         err_q    <= 1'b0;
`ifdef FLAG_DIV_SCHED_PHASE_EN
         sh_ph_q  <= '0;
`endif
      end else begin
         state_q  <= state_d;
         sh_ch_q  <= sh_ch_d;
         sh_div_q <= sh_div_d;
         sh_en_q  <= sh_en_d;
         err_q    <= err_d;
`ifdef FLAG_DIV_SCHED_PHASE_EN
         sh_ph_q  <= sh_ph_d;
`endif
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      flag_div_chan #(
         .DIV_W   (DIV_W),
         .RST_DIV (RST_DIV)
      ) u_chan (
         .sys_clk   (sys_clk),
         .sys_rst_n (sys_rst_n),
         .commit_i  (commit & (sh_ch_q == CH_W'(i))),
         .div_i     (sh_div_q),
         .en_i      (sh_en_q),
`ifdef FLAG_DIV_SCHED_PHASE_EN
         .phase_i   (sh_ph_q),
`endif
         .sync_i    (sync_req),
         .flag_o    (clk_flag[i]),
         .wrap_o    (wrap[i]),
         .en_o      (chan_en[i])
      );
   end

endmodule
